// File: rtl/s27_frame_sequencer.sv
// Rolled s27 evaluator: accepts a packed multi-frame stimulus plus initial flop state,
// steps the 3-flop s27 machine one frame per clock, and returns per-frame G17 and final D-state.
module s27_frame_sequencer #(
    parameter int FRAMES = 5,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*FRAMES-1:0]   in_frames,
    input  logic [2:0]            init_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FRAMES-1:0]     g17,
    output logic [2:0]            final_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [4*FRAMES-1:0] frames_sr, frames_sr_next;
    logic [2:0]          q, q_next;
    logic [FRAMES-1:0]   g17_next;
    logic [2:0]          final_state_next;

    // Current frame always sits in the low nibble; the register shifts right each RUN cycle.
    logic g0, g1, g2, g3;
    logic g5, g6, g7;
    logic n7, n8, n10;
    logic g17_bit;
    logic [2:0] d;
    logic last_frame;

    assign {g3, g2, g1, g0} = frames_sr[3:0];
    assign {g7, g6, g5}     = q;

    assign n8      = ~g1 & g3 & ~g7;
    assign n7      = g6 & ~g0;
    assign n10     = ~(n7 | n8);
    assign g17_bit = g5 | n10;
    assign d[0]    = g0 & ~(~g5 & n8);
    assign d[1]    = ~g17_bit;
    assign d[2]    = ~g2 & (g7 | g1);

    assign last_frame = (cnt == CNT_W'(FRAMES - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_next       = state;
        cnt_next         = cnt;
        frames_sr_next   = frames_sr;
        q_next           = q;
        g17_next         = g17;
        final_state_next = final_state;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    frames_sr_next = in_frames;
                    q_next         = init_state;
                    cnt_next       = '0;
                    g17_next       = '0;
                    state_next     = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < FRAMES; k++) begin
                    if (cnt == CNT_W'(k)) g17_next[k] = g17_bit;
                end
                q_next         = d;
                frames_sr_next = frames_sr >> 4;
                if (last_frame) begin
                    final_state_next = d;
                    state_next       = DONE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so outputs never depend on inputs combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            frames_sr   <= '0;
            q           <= '0;
            g17         <= '0;
            final_state <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state       <= state_next;
            cnt         <= cnt_next;
            frames_sr   <= frames_sr_next;
            q           <= q_next;
            g17         <= g17_next;
            final_state <= final_state_next;
            in_ready    <= (state_next == IDLE);
            out_valid   <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_s27_frame_sequencer.sv
// Directed self-checking bench for s27_frame_sequencer: reset, hand-computed s27 jobs,
// partial-result visibility, input capture, backpressure and mid-run abort.
module tb_s27_frame_sequencer;

    localparam int FRAMES = 5;
    localparam int CNT_W  = 5;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [4*FRAMES-1:0] in_frames;
    logic [2:0]          init_state;
    logic                out_valid;
    logic                out_ready;
    logic [FRAMES-1:0]   g17;
    logic [2:0]          final_state;

    int checks = 0;
    int errors = 0;

    s27_frame_sequencer #(.FRAMES(FRAMES), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_frames   (in_frames),
        .init_state  (init_state),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .g17         (g17),
        .final_state (final_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a job for one accept edge, then scramble the inputs to prove they were captured.
    task automatic start_job(input logic [4*FRAMES-1:0] frames, input logic [2:0] init);
        in_frames  = frames;
        init_state = init;
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
        in_frames  = ~frames;
        init_state = ~init;
    endtask

    // Count edges after accept until out_valid; an expired budget shows up as a wrong latency.
    task automatic wait_done(input string tag, input int already);
        int n;
        n = already;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(FRAMES));
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ir_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_frames  = '0;
        init_state = '0;

        // Reset values
        #1;
        check("rst_in_ready",  32'(in_ready),    32'd0);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_g17",       32'(g17),         32'd0);
        check("rst_final",     32'(final_state), 32'd0);
        step();
        step();
        rst = 1'b0;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check("rel_in_ready_high", 32'(in_ready), 32'd1);

        // All-zero frames from 000: G17 stays 1 every frame, state stays 000.
        start_job(20'h00000, 3'b000);
        check("z_in_ready_run", 32'(in_ready), 32'd0);
        step();
        step();
        check("z_partial_g17", 32'(g17), 32'h03);
        check("z_partial_ov",  32'(out_valid), 32'd0);
        wait_done("z", 2);
        check("z_g17",   32'(g17),         32'h1F);
        check("z_final", 32'(final_state), 32'd0);
        handoff("z");
        check("z_idle_hold_g17", 32'(g17), 32'h1F);

        // Frame0 = 1001 from 000: drives Q1 high, which then holds G17 low.
        start_job(20'h00009, 3'b000);
        wait_done("a", 0);
        check("a_g17",   32'(g17),         32'h00);
        check("a_final", 32'(final_state), 32'h2);
        handoff("a");

        // Mixed job from 010: frames 0000,0001,1000,1000,0010 -> g17 00110, final 110.
        start_job(20'h28810, 3'b010);
        wait_done("m", 0);
        check("m_g17",   32'(g17),         32'h06);
        check("m_final", 32'(final_state), 32'h6);

        // Backpressure: hold out_ready low and wiggle the job inputs for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            in_valid   = i[0];
            in_frames  = 20'($urandom);
            init_state = 3'($urandom);
            step();
            check("bp_out_valid", 32'(out_valid),   32'd1);
            check("bp_in_ready",  32'(in_ready),    32'd0);
            check("bp_g17",       32'(g17),         32'h06);
            check("bp_final",     32'(final_state), 32'h6);
        end
        in_valid = 1'b0;
        handoff("m");
        check("m_idle_hold_final", 32'(final_state), 32'h6);

        // Abort in cycle 2 of a run; reset clears outputs without waiting for a clock.
        start_job(20'h00000, 3'b000);
        step();
        step();
        check("ab_partial_g17", 32'(g17), 32'h03);
        #2;
        rst = 1'b1;
        #1;
        check("ab_g17",       32'(g17),         32'd0);
        check("ab_final",     32'(final_state), 32'd0);
        check("ab_out_valid", 32'(out_valid),   32'd0);
        check("ab_in_ready",  32'(in_ready),    32'd0);
        step();
        rst = 1'b0;
        step();
        check("ab_in_ready_back", 32'(in_ready),  32'd1);
        check("ab_out_valid_low", 32'(out_valid), 32'd0);

        // From 100 with frame4 = 0100: G17 high throughout, G2 clears D2 at the end.
        // out_ready is held high during RUN, which must not disturb the job.
        out_ready = 1'b1;
        start_job(20'h40000, 3'b100);
        out_ready = 1'b1;
        wait_done("h", 0);
        check("h_g17",   32'(g17),         32'h1F);
        check("h_final", 32'(final_state), 32'h0);
        step();
        out_ready = 1'b0;
        check("h_ov_drop", 32'(out_valid), 32'd0);
        check("h_ir_rise", 32'(in_ready),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
